// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int DEPTH_DEFAULT  = 256;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 8-to-32 assembler; word_valid pulses the cycle after the 4th byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [1:0]        byte_cnt,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-BYTE_W-1:0] low_bytes;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= '0;
      low_bytes  <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_cnt <= '0;
      end else if (byte_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
          word       <= {byte_data, low_bytes};
          word_valid <= 1'b1;
        end else begin
          low_bytes[{byte_cnt, 3'b000} +: BYTE_W] <= byte_data;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian image into instruction memory while holding the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int IDX_W = $clog2(DEPTH + 1);

  state_t            state;
  logic [1:0]        hdr_cnt;
  logic [WORD_W-1:0] count;
  logic [WORD_W-1:0] hdr_full;
  logic [IDX_W-1:0]  word_index;
  logic [1:0]        pk_cnt;
  logic              accept;
  logic              pk_clear;
  logic              data_accept;
  logic              word_done;
  logic              last_word;

  assign accept      = in_valid && in_ready;
  assign data_accept = accept && (state == DATA);
  assign word_done   = data_accept && (pk_cnt == 2'(BYTES_PER_WORD - 1));
  assign last_word   = (32'(word_index) + 32'd1) == count;
  assign pk_clear    = start && (state == IDLE || state == DONE || state == ERR);

  // Header value including the byte on the bus, so the 4th accept can decide the next state.
  always_comb begin
    hdr_full = count;
    hdr_full[{hdr_cnt, 3'b000} +: BYTE_W] = in_data;
  end

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .byte_valid (data_accept),
    .byte_data  (in_data),
    .byte_cnt   (pk_cnt),
    .word_valid (mem_we),
    .word       (mem_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hdr_cnt    <= '0;
      count      <= '0;
      word_index <= '0;
      mem_addr   <= '0;
      in_ready   <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= HDR;
            hdr_cnt    <= '0;
            count      <= '0;
            word_index <= '0;
            in_ready   <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
          end else if (state == DONE) begin
            // Releases the core one cycle after DONE is entered, after the final write.
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
        HDR: begin
          if (accept) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            count   <= hdr_full;
            if (hdr_cnt == 2'(BYTES_PER_WORD - 1)) begin
              if (hdr_full == '0) begin
                state    <= DONE;
                in_ready <= 1'b0;
              end else if (hdr_full > 32'(DEPTH)) begin
                state    <= ERR;
                in_ready <= 1'b0;
                error    <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (word_done) begin
            mem_addr   <= 32'({word_index, 2'b00});
            word_index <= word_index + 1'b1;
            if (last_word) begin
              state    <= DONE;
              in_ready <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
